// File: rtl/fma16_tv_pkg.sv
// Shared constants, FSM state type and hex-character helper for the fma16 test-vector recorder.
package fma16_tv_pkg;

    localparam int TV_WIDTH  = 76;
    localparam int TV_DIGITS = 19;

    localparam int X_LSB    = 60;
    localparam int Y_LSB    = 44;
    localparam int Z_LSB    = 28;
    localparam int CTRL_LSB = 20;
    localparam int RES_LSB  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_NL    = 2'd2
    } tv_state_e;

    // Lowercase ASCII hex: 0-9 -> 0x30-0x39, a-f -> 0x61-0x66.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h57 + {4'h0, n};
    endfunction

endpackage

// File: rtl/fma16_tv_recorder_if.sv
// Capture-side and character-stream signals of the recorder. The master drives captures and
// tx_ready; the slave (the recorder) drives the character stream, status and debug state.
interface fma16_tv_recorder_if;
    import fma16_tv_pkg::*;

    logic        cap_valid;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        mul;
    logic        add;
    logic        negp;
    logic        negz;
    logic [1:0]  roundmode;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        finish;

    // tx handshake: a character moves on a rising edge where tx_valid && tx_ready;
    // tx_data stays constant while tx_valid && !tx_ready.
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    logic [31:0] rec_count;
    logic        overflow;
    logic        done;
    tv_state_e   state;

    modport master (
        output cap_valid, x, y, z, mul, add, negp, negz, roundmode, result, flags, finish,
        output tx_ready,
        input  tx_valid, tx_data, rec_count, overflow, done, state
    );

    modport slave (
        input  cap_valid, x, y, z, mul, add, negp, negz, roundmode, result, flags, finish,
        input  tx_ready,
        output tx_valid, tx_data, rec_count, overflow, done, state
    );

endinterface

// File: rtl/fma16_tv_recorder_fifo.sv
// Record FIFO with wrap-bit pointers; rdata shows the head entry combinationally.
module tv_fifo #(
    parameter int WIDTH = 76,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    // Same slot index but different wrap bit means the writer is a full lap ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fma16_tv_recorder.sv
// Packs fma16 transactions into 76-bit vectors, queues them and streams each as a hex text line.
module fma16_tv_recorder
    import fma16_tv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic                clk,
    input logic                reset,
    fma16_tv_recorder_if.slave bus
);
    logic [TV_WIDTH-1:0] rec;
    logic [TV_WIDTH-1:0] head;
    logic [TV_WIDTH-1:0] shreg;
    logic [4:0]          idx;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                accept;
    logic                finish_seen;
    logic [31:0]         rec_count;
    logic                overflow;
    logic                tx_valid;
    logic [7:0]          tx_data;
    tv_state_e           state;
    tv_state_e           state_next;

    assign rec = {bus.x, bus.y, bus.z, 2'b00, bus.roundmode,
                  bus.mul, bus.add, bus.negp, bus.negz, bus.result, bus.flags};

    // A full FIFO still takes the record when the serializer pops the head this cycle.
    assign pop      = (state == ST_IDLE) && !empty;
    assign push_req = bus.cap_valid && !finish_seen;
    assign push     = push_req && (!full || pop);
    assign accept   = tx_valid && bus.tx_ready;

    tv_fifo #(
        .WIDTH (TV_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (rec),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!empty) state_next = ST_DIGIT;
            ST_DIGIT: if (accept && idx == 5'(TV_DIGITS - 1)) state_next = ST_NL;
            ST_NL:    if (accept) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            ST_DIGIT: begin
                tx_valid = 1'b1;
                tx_data  = hex_char(shreg[TV_WIDTH-1 -: 4]);
            end
            ST_NL: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0a;
            end
            default: ;
        endcase
    end

    // The current digit always sits in the top nibble; shift after each accepted digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            idx   <= '0;
        end else if (pop) begin
            shreg <= head;
            idx   <= '0;
        end else if (state == ST_DIGIT && accept) begin
            shreg <= shreg << 4;
            idx   <= idx + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_count   <= '0;
            overflow    <= 1'b0;
            finish_seen <= 1'b0;
        end else begin
            if (push)              rec_count   <= rec_count + 32'd1;
            if (push_req && !push) overflow    <= 1'b1;
            if (bus.finish)        finish_seen <= 1'b1;
        end
    end

    assign bus.tx_valid  = tx_valid;
    assign bus.tx_data   = tx_data;
    assign bus.rec_count = rec_count;
    assign bus.overflow  = overflow;
    assign bus.done      = finish_seen && empty && (state == ST_IDLE);
    assign bus.state     = state;

endmodule

// File: tb/tb_fma16_tv_recorder.sv
// Directed bench for fma16_tv_recorder: hand-computed hex lines, stalls, overflow, finish, reset.
module tb_fma16_tv_recorder;
    import fma16_tv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fma16_tv_recorder_if bus();

    fma16_tv_recorder #(.DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int nl_seen;
    logic [7:0] rx_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [15:0] xv, input logic [15:0] yv, input logic [15:0] zv,
                           input logic [1:0] rm, input logic [3:0] ctl, input logic [15:0] res,
                           input logic [3:0] fl);
        bus.x = xv; bus.y = yv; bus.z = zv; bus.roundmode = rm;
        {bus.mul, bus.add, bus.negp, bus.negz} = ctl;
        bus.result = res; bus.flags = fl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.cap_valid = 1'b0; bus.finish = 1'b0; bus.tx_ready = 1'b0;
        set_rec(16'h0, 16'h0, 16'h0, 2'b00, 4'b0000, 16'h0, 4'h0);
        step(); step();
        reset = 1'b0;
    endtask

    // Drives tx_ready (constant 1, or 1-0-0-1 when bp) and records accepted characters.
    task automatic run_tx(input int max_cyc, input int lines, input bit bp, output int cyc);
        int ph = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_d = 8'h00;
        cyc = 0;
        nl_seen = 0;
        while (nl_seen < lines && cyc < max_cyc) begin
            bus.tx_ready = bp ? (ph == 0 || ph == 3) : 1'b1;
            if (prev_stall) begin
                n_tests++;
                if (bus.tx_data !== prev_d) begin
                    n_fail++;
                    $display("FAIL hold: tx_data=%h required %h", bus.tx_data, prev_d);
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                rx_q.push_back(bus.tx_data);
                if (bus.tx_data == 8'h0a) nl_seen++;
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_d = bus.tx_data;
            ph = (ph + 1) % 4;
            step();
            cyc++;
        end
        bus.tx_ready = 1'b0;
        n_tests++;
        if (nl_seen < lines) begin
            n_fail++;
            $display("FAIL tx_timeout: lines=%0d required %0d", nl_seen, lines);
        end
    endtask

    function automatic string q2str(input int base);
        string s = "";
        for (int i = 0; i < 19; i++)
            if (base + i < rx_q.size()) s = $sformatf("%s%c", s, rx_q[base + i]);
        return s;
    endfunction

    task automatic check_line(input string name, input string exp, input int base);
        bit bad = 1'b0;
        logic [7:0] c;
        n_tests++;
        if (rx_q.size() < base + 20) bad = 1'b1;
        else begin
            for (int i = 0; i < 19; i++) begin
                c = exp[i];
                if (rx_q[base + i] !== c) bad = 1'b1;
            end
            if (rx_q[base + 19] !== 8'h0a) bad = 1'b1;
        end
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" required \"%s\" + newline", name, q2str(base), exp);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int extra = 0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (bus.tx_valid) extra++;
            step();
        end
        bus.tx_ready = 1'b0;
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL %s: %0d extra valid cycles, required 0", name, extra);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests += 5;
        if (bus.tx_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_valid: %b required 0", bus.tx_valid); end
        if (bus.tx_data !== 8'h00)     begin n_fail++; $display("FAIL rst_data: %h required 00", bus.tx_data); end
        if (bus.rec_count !== 32'd0)   begin n_fail++; $display("FAIL rst_count: %0d required 0", bus.rec_count); end
        if (bus.overflow !== 1'b0)     begin n_fail++; $display("FAIL rst_ovf: %b required 0", bus.overflow); end
        if (bus.done !== 1'b0)         begin n_fail++; $display("FAIL rst_done: %b required 0", bus.done); end
    endtask

    task automatic test_single();
        int cyc;
        set_rec(16'h3c00, 16'h3c00, 16'h0000, 2'b01, 4'b1000, 16'h3c00, 4'h0);
        bus.tx_ready = 1'b1;
        bus.cap_valid = 1'b1;
        step();
        bus.cap_valid = 1'b0;
        n_tests += 2;
        if (bus.tx_valid !== 1'b0)   begin n_fail++; $display("FAIL lat_c1: tx_valid=%b required 0", bus.tx_valid); end
        if (bus.rec_count !== 32'd1) begin n_fail++; $display("FAIL single_count: %0d required 1", bus.rec_count); end
        step();
        n_tests++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h33) begin
            n_fail++;
            $display("FAIL lat_c2: valid=%b data=%h required 1/33", bus.tx_valid, bus.tx_data);
        end
        rx_q.delete();
        run_tx(100, 1, 1'b0, cyc);
        check_line("single_line", "3c003c000000183c000", 0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset();
        bus.tx_ready = 1'b1;
        bus.cap_valid = 1'b1;
        set_rec(16'h1234, 16'h5678, 16'h9abc, 2'b10, 4'b1101, 16'hdef0, 4'ha);
        step();
        set_rec(16'habcd, 16'hef01, 16'h2345, 2'b11, 4'b0110, 16'h6789, 4'h5);
        step();
        bus.cap_valid = 1'b0;
        rx_q.delete();
        run_tx(200, 2, 1'b0, cyc);
        check_line("b2b_line0", "123456789abc2ddef0a", 0);
        check_line("b2b_line1", "abcdef0123453667895", 20);
        n_tests++;
        if (cyc != 41) begin n_fail++; $display("FAIL b2b_cycles: %0d required 41", cyc); end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        set_rec(16'h3c00, 16'h3c00, 16'h0000, 2'b01, 4'b1000, 16'h3c00, 4'h0);
        bus.cap_valid = 1'b1;
        step();
        bus.cap_valid = 1'b0;
        rx_q.delete();
        run_tx(300, 1, 1'b1, cyc);
        check_line("bp_line", "3c003c000000183c000", 0);
        expect_quiet("bp_no_dup", 20);
    endtask

    task automatic test_overflow();
        int cyc;
        bit bad = 1'b0;
        string xs;
        logic [7:0] c;
        do_reset();
        bus.cap_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_rec(16'(i), 16'h0, 16'h0, 2'b00, 4'b0000, 16'h0, 4'h0);
            step();
        end
        bus.cap_valid = 1'b0;
        n_tests += 2;
        if (bus.rec_count !== 32'd9) begin n_fail++; $display("FAIL ovf_count: %0d required 9", bus.rec_count); end
        if (bus.overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_flag: %b required 1", bus.overflow); end
        rx_q.delete();
        run_tx(400, 9, 1'b0, cyc);
        n_tests++;
        for (int k = 0; k < 9; k++) begin
            xs = $sformatf("%04h", k);
            for (int j = 0; j < 4; j++) begin
                c = xs[j];
                if (rx_q.size() < 20 * k + 4 || rx_q[20 * k + j] !== c) bad = 1'b1;
            end
        end
        if (bad) begin n_fail++; $display("FAIL ovf_order: lines do not carry x=0..8 in order"); end
        expect_quiet("ovf_extra_lines", 30);
    endtask

    task automatic test_reset_midline();
        int acc = 0;
        int cyc = 0;
        set_rec(16'h3c00, 16'h3c00, 16'h0000, 2'b01, 4'b1000, 16'h3c00, 4'h0);
        bus.cap_valid = 1'b1;
        step(); step();
        bus.cap_valid = 1'b0;
        bus.tx_ready = 1'b1;
        while (acc < 5 && cyc < 50) begin
            if (bus.tx_valid && bus.tx_ready) acc++;
            step();
            cyc++;
        end
        bus.tx_ready = 1'b0;
        reset = 1'b1;
        step();
        n_tests += 4;
        if (bus.tx_valid !== 1'b0)   begin n_fail++; $display("FAIL mid_valid: %b required 0", bus.tx_valid); end
        if (bus.rec_count !== 32'd0) begin n_fail++; $display("FAIL mid_count: %0d required 0", bus.rec_count); end
        if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL mid_ovf: %b required 0", bus.overflow); end
        if (bus.state !== ST_IDLE)   begin n_fail++; $display("FAIL mid_state: %0d required IDLE", bus.state); end
        reset = 1'b0;
        set_rec(16'h1234, 16'h5678, 16'h9abc, 2'b10, 4'b1101, 16'hdef0, 4'ha);
        bus.cap_valid = 1'b1;
        step();
        bus.cap_valid = 1'b0;
        step();
        n_tests++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h31) begin
            n_fail++;
            $display("FAIL mid_first: valid=%b data=%h required 1/31", bus.tx_valid, bus.tx_data);
        end
        rx_q.delete();
        run_tx(100, 1, 1'b0, cyc);
        check_line("mid_line", "123456789abc2ddef0a", 0);
        expect_quiet("mid_fifo_empty", 30);
    endtask

    task automatic test_push_pop_full();
        int cyc = 0;
        do_reset();
        bus.cap_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_rec(16'(i), 16'h0, 16'h0, 2'b00, 4'b0000, 16'h0, 4'h0);
            step();
        end
        bus.cap_valid = 1'b0;
        bus.tx_ready = 1'b1;
        step();
        while (bus.state !== ST_IDLE && cyc < 60) begin
            step();
            cyc++;
        end
        bus.tx_ready = 1'b0;
        set_rec(16'h0bad, 16'h0, 16'h0, 2'b00, 4'b0000, 16'h0, 4'h0);
        bus.cap_valid = 1'b1;
        step();
        bus.cap_valid = 1'b0;
        n_tests += 2;
        if (bus.rec_count !== 32'd10) begin n_fail++; $display("FAIL pp_count: %0d required 10", bus.rec_count); end
        if (bus.overflow !== 1'b0)    begin n_fail++; $display("FAIL pp_ovf: %b required 0", bus.overflow); end
        rx_q.delete();
        run_tx(400, 9, 1'b0, cyc);
        check_line("pp_last_line", "0bad000000000000000", 160);
    endtask

    task automatic test_finish_done();
        int cyc;
        do_reset();
        bus.cap_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rec(16'h1111 * 16'(i + 1), 16'h0, 16'h0, 2'b00, 4'b0000, 16'h0, 4'h0);
            step();
        end
        bus.cap_valid = 1'b0;
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        bus.cap_valid = 1'b1;
        step();
        bus.cap_valid = 1'b0;
        n_tests += 2;
        if (bus.rec_count !== 32'd3) begin n_fail++; $display("FAIL fin_count: %0d required 3", bus.rec_count); end
        if (bus.done !== 1'b0)       begin n_fail++; $display("FAIL fin_done_early: %b required 0", bus.done); end
        rx_q.delete();
        run_tx(200, 3, 1'b0, cyc);
        n_tests++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL fin_done: %b required 1", bus.done); end
        check_line("fin_line2", "3333000000000000000", 40);
        bus.cap_valid = 1'b1;
        step(); step();
        bus.cap_valid = 1'b0;
        n_tests += 2;
        if (bus.done !== 1'b1)       begin n_fail++; $display("FAIL fin_done_hold: %b required 1", bus.done); end
        if (bus.rec_count !== 32'd3) begin n_fail++; $display("FAIL fin_count_hold: %0d required 3", bus.rec_count); end
    endtask

    task automatic test_finish_with_capture();
        do_reset();
        set_rec(16'h3c00, 16'h3c00, 16'h0000, 2'b01, 4'b1000, 16'h3c00, 4'h0);
        bus.cap_valid = 1'b1;
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        step();
        bus.cap_valid = 1'b0;
        n_tests++;
        if (bus.rec_count !== 32'd1) begin n_fail++; $display("FAIL fin_same_cycle: %0d required 1", bus.rec_count); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.cap_valid = 1'b0;
        bus.finish = 1'b0;
        bus.tx_ready = 1'b0;
        set_rec(16'h0, 16'h0, 16'h0, 2'b00, 4'b0000, 16'h0, 4'h0);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_midline();
        test_push_pop_full();
        test_finish_done();
        test_finish_with_capture();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
